i2c_target: RTL
===============

Name: i2c_target

Overview:
- I2C target (slave) endpoint answering a single 7-bit address; counterpart to the team's I2C master.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches the address, ACKs, and shifts data both ways.
- Sits between the pad-level open-drain bus and a simple byte-wide register/FIFO interface.
- Supports standard-mode timing only: clk must be ≥ 16× SCL frequency; no clock stretching.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit address this block responds to.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- SCL  input  1  bus clock from the master; pulled up externally.
- SDA  inout  1  bus data, open-drain: driven 0 or z only, never 1.
- tx_data  input  8  byte returned on the next read byte; sampled when tx_load pulses.
- rx_data  output  8  last byte received in a write transfer.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- tx_load  output  1  one-cycle pulse when tx_data is captured into the shift register.
- busy  output  1  high from an addressed START until STOP or NACK.
- addr_rw  output  1  R/W bit of the current addressed transfer (1 = read).

Behaviour:
- Reset values: rx_data=0, rx_valid=0, tx_load=0, busy=0, addr_rw=0. SDA released (z), state=IDLE, bit counter=0.
- SCL and SDA each pass through a 2-flop synchronizer. Edges are detected from the synced values, giving 3 clk of latency from pin to event.
- Bus events:
  - START: synced SDA falls while synced SCL=1.
  - STOP: synced SDA rises while synced SCL=1.
  - Data is sampled on SCL rise. The target changes SDA only on SCL fall.
- STOP from any state → IDLE, SDA released, busy=0.
- START from any state, including repeated START mid-byte → ADDR, counter cleared.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first. After the 8th rise, compare [7:1] with TARGET_ADDR.
    - Match → ADDR_ACK, busy=1, addr_rw=bit0.
    - Mismatch → WAIT_STOP.
  - ADDR_ACK: drive SDA=0 on the next SCL fall. On the following fall:
    - Write → release SDA, go to RX.
    - Read → pulse tx_load, load tx_data, drive the MSB (0→drive low, 1→release), go to TX.
  - RX: shift 8 bits on rises. In the clk cycle after the 8th rise is detected, update rx_data and pulse rx_valid. Then RX_ACK.
  - RX_ACK: drive SDA=0 on the next fall, release on the following fall, return to RX. The ACK is unconditional.
  - TX: on each fall, present the next bit. On the fall after the 8th bit, release SDA and go to TX_ACK.
  - TX_ACK: sample SDA on the rise.
    - 0 (ACK) → on the next fall pulse tx_load, load tx_data, drive the MSB, go to TX.
    - 1 (NACK) → WAIT_STOP, busy=0.
  - WAIT_STOP: SDA released, ignore bus until STOP or START.
- Bit counter is 3 bits and wraps 7→0 at each byte boundary.
- Reset mid-transfer releases SDA within the same clk cycle it is sampled; the block ignores the bus until the next START.

Optional Feature:
- GENERAL_CALL_EN defined: address byte 8'h00 (general call, write) is also ACKed and handled as a write transfer. Received bytes go to rx_data/rx_valid as normal.
- Address 8'h01 (general call with R=1) is not ACKed.
- Without the macro: address 0 is treated as a mismatch → WAIT_STOP.

Test Plan:
- Write 0xA5 to address 0x50: START, 0xA0, ACK, 0xA5, STOP → SDA low in both ACK slots; rx_data=0xA5 with one rx_valid pulse; busy low after STOP.
- Address 0x51 write: START, 0xA2 → no ACK (SDA=z in the 9th clock), busy stays 0, no rx_valid.
- Read with tx_data=0x3C, master ACK, then tx_data=0xC3, master NACK, STOP → bus bytes 0x3C then 0xC3; exactly two tx_load pulses; addr_rw=1; SDA released after NACK.
- Write 0x11, then repeated START with 0xA1 (read) → rx_data=0x11, addr_rw switches to 1, read byte equals tx_data.
- STOP after 4 bits of a data byte, and separately reset asserted mid-ADDR → no rx_valid, busy=0, SDA released; next valid write of 0x7E is received correctly.
- GENERAL_CALL_EN defined: START, 0x00, 0x06, STOP → both ACKed, rx_data=0x06. Without the macro, 0x00 is NACKed.

Source files
------------

// File: rtl/i2c_target.sv
// I2C target endpoint for a single 7-bit address: oversampled SCL/SDA, START/STOP detection,
// address match with ACK, byte receive/transmit. Define GENERAL_CALL_EN to also accept general-call writes.
`timescale 1ns/1ps
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_load,
    output logic       busy,
    output logic       addr_rw
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK, S_WAIT_STOP
    } state_t;

    state_t     state_reg, state_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] shift_reg, shift_next;
    logic [7:0] rx_data_reg, rx_data_next;
    logic       ack_phase_reg, ack_phase_next;
    logic       sda_low_reg, sda_low_next;
    logic       rx_valid_reg, rx_valid_next;
    logic       tx_load_reg, tx_load_next;
    logic       busy_reg, busy_next;
    logic       addr_rw_reg, addr_rw_next;

    // Index 1 = SCL, index 0 = SDA; synchronizers idle high like the bus.
    logic [1:0] pin_in, pin_sync, pin_prev;
    assign pin_in = {SCL, SDA};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg, sync_reg, prev_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                    prev_reg <= 1'b1;
                end else begin
                    meta_reg <= pin_in[gi];
                    sync_reg <= meta_reg;
                    prev_reg <= sync_reg;
                end
            end
            assign pin_sync[gi] = sync_reg;
            assign pin_prev[gi] = prev_reg;
        end
    endgenerate

    logic scl_s, sda_s, scl_rise, scl_fall, start_evt, stop_evt;
    assign scl_s     = pin_sync[1];
    assign sda_s     = pin_sync[0];
    assign scl_rise  = scl_s & ~pin_prev[1];
    assign scl_fall  = ~scl_s & pin_prev[1];
    assign start_evt = scl_s & pin_prev[0] & ~sda_s;
    assign stop_evt  = scl_s & ~pin_prev[0] & sda_s;

    logic [7:0] rx_byte;
    logic       addr_hit;
    assign rx_byte = {shift_reg[6:0], sda_s};
`ifdef GENERAL_CALL_EN
    assign addr_hit = (rx_byte[7:1] == TARGET_ADDR) || (rx_byte == 8'h00);
`else
    assign addr_hit = (rx_byte[7:1] == TARGET_ADDR);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            bit_cnt_reg   <= 3'd0;
            shift_reg     <= 8'd0;
            rx_data_reg   <= 8'd0;
            ack_phase_reg <= 1'b0;
            sda_low_reg   <= 1'b0;
            rx_valid_reg  <= 1'b0;
            tx_load_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            addr_rw_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            rx_data_reg   <= rx_data_next;
            ack_phase_reg <= ack_phase_next;
            sda_low_reg   <= sda_low_next;
            rx_valid_reg  <= rx_valid_next;
            tx_load_reg   <= tx_load_next;
            busy_reg      <= busy_next;
            addr_rw_reg   <= addr_rw_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (stop_evt) begin
            state_next = S_IDLE;
        end else if (start_evt) begin
            state_next = S_ADDR;
        end else begin
            case (state_reg)
                S_ADDR:     if (scl_rise && bit_cnt_reg == 3'd7)
                                state_next = addr_hit ? S_ADDR_ACK : S_WAIT_STOP;
                S_ADDR_ACK: if (scl_fall && ack_phase_reg)
                                state_next = addr_rw_reg ? S_TX : S_RX;
                S_RX:       if (scl_rise && bit_cnt_reg == 3'd7) state_next = S_RX_ACK;
                S_RX_ACK:   if (scl_fall && ack_phase_reg) state_next = S_RX;
                S_TX:       if (scl_fall && bit_cnt_reg == 3'd7) state_next = S_TX_ACK;
                S_TX_ACK: begin
                    if (scl_rise && sda_s)
                        state_next = S_WAIT_STOP;
                    else if (scl_fall && ack_phase_reg)
                        state_next = S_TX;
                end
                default:    state_next = state_reg;
            endcase
        end
    end

    // ACK slots take two SCL falls: the first starts driving low, the second ends the slot.
    always_comb begin
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        rx_data_next   = rx_data_reg;
        ack_phase_next = ack_phase_reg;
        sda_low_next   = sda_low_reg;
        rx_valid_next  = 1'b0;
        tx_load_next   = 1'b0;
        busy_next      = busy_reg;
        addr_rw_next   = addr_rw_reg;
        if (stop_evt) begin
            bit_cnt_next   = 3'd0;
            ack_phase_next = 1'b0;
            sda_low_next   = 1'b0;
            busy_next      = 1'b0;
        end else if (start_evt) begin
            bit_cnt_next   = 3'd0;
            ack_phase_next = 1'b0;
            sda_low_next   = 1'b0;
        end else begin
            case (state_reg)
                S_ADDR: if (scl_rise) begin
                    shift_next     = rx_byte;
                    bit_cnt_next   = bit_cnt_reg + 3'd1;
                    ack_phase_next = 1'b0;
                    if (bit_cnt_reg == 3'd7) begin
                        busy_next = addr_hit;
                        if (addr_hit) addr_rw_next = rx_byte[0];
                    end
                end
                S_ADDR_ACK: if (scl_fall) begin
                    if (!ack_phase_reg) begin
                        sda_low_next   = 1'b1;
                        ack_phase_next = 1'b1;
                    end else begin
                        ack_phase_next = 1'b0;
                        if (addr_rw_reg) begin
                            tx_load_next = 1'b1;
                            shift_next   = tx_data;
                            sda_low_next = ~tx_data[7];
                        end else begin
                            sda_low_next = 1'b0;
                        end
                    end
                end
                S_RX: if (scl_rise) begin
                    shift_next     = rx_byte;
                    bit_cnt_next   = bit_cnt_reg + 3'd1;
                    ack_phase_next = 1'b0;
                    if (bit_cnt_reg == 3'd7) begin
                        rx_data_next  = rx_byte;
                        rx_valid_next = 1'b1;
                    end
                end
                S_RX_ACK: if (scl_fall) begin
                    sda_low_next   = ~ack_phase_reg;
                    ack_phase_next = ~ack_phase_reg;
                end
                S_TX: if (scl_fall) begin
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        sda_low_next   = 1'b0;
                        ack_phase_next = 1'b0;
                    end else begin
                        shift_next   = {shift_reg[6:0], shift_reg[7]};
                        sda_low_next = ~shift_reg[6];
                    end
                end
                S_TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) busy_next = 1'b0;
                        else       ack_phase_next = 1'b1;
                    end else if (scl_fall && ack_phase_reg) begin
                        ack_phase_next = 1'b0;
                        tx_load_next   = 1'b1;
                        shift_next     = tx_data;
                        sda_low_next   = ~tx_data[7];
                    end
                end
                default: sda_low_next = 1'b0;
            endcase
        end
    end

    // Reset gates the pad driver directly so SDA lets go in the very cycle reset is seen.
    assign SDA      = (sda_low_reg && !reset) ? 1'b0 : 1'bz;
    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
    assign tx_load  = tx_load_reg;
    assign busy     = busy_reg;
    assign addr_rw  = addr_rw_reg;

endmodule
